i2c_id_rom_target: RTL and testbench
====================================

Name: i2c_id_rom_target

Overview:
- I2C target (responder) that emulates the receiver-module ident EEPROM (24C02-style byte-addressed memory).
- Sits on the FPGA side of an open-drain I2C pair through the team's I2C pad buffer (oe=1 pulls line low, oe=0 releases).
- Lets the on-chip Avalon I2C host and bench firmware exercise the ident path without a physical EEPROM.
- A local write port preloads or updates contents; a strobe reports each byte written over the bus.

Parameters:
- DEV_ADDR, 7'h50, 7-bit target address matched against the first byte after START.
- DEPTH_LOG2, 4, memory depth 2^DEPTH_LOG2 bytes; pointer width is DEPTH_LOG2.
- FILTER_LEN, 3, consecutive equal samples required before a filtered SCL/SDA level changes.
- STRETCH_CYC, 8, clk cycles SCL is held low after each ACK falling edge (only with I2C_TGT_STRETCH_EN).

Ports:
- clk_50_max10  in  1  system clock, 50 MHz.
- fpga_resetn  in  1  asynchronous active-low reset.
- scl_in  in  1  raw SCL from pad buffer.
- sda_in  in  1  raw SDA from pad buffer.
- sda_oe  out  1  1 = pull SDA low.
- scl_oe  out  1  1 = pull SCL low (clock stretch).
- cfg_we  in  1  local write enable, one byte per cycle.
- cfg_addr  in  DEPTH_LOG2  local write address.
- cfg_wdata  in  8  local write data.
- wr_strobe  out  1  one-cycle pulse when an I2C data byte is committed.
- wr_addr  out  DEPTH_LOG2  address of the committed byte.
- wr_data  out  8  committed byte.
- cfg_collision  out  1  one-cycle pulse when a cfg write is dropped.
- busy  out  1  addressed transaction in progress.

Behaviour:
- Reset: sda_oe, scl_oe, wr_strobe, cfg_collision and busy = 0; wr_addr, wr_data and pointer = 0; memory cleared to 8'h00; FSM in IDLE. Reset asserted mid-transfer releases both lines immediately (asynchronous).
- Input path: 2-FF synchronizer, then glitch filter. A filtered level changes only after FILTER_LEN identical consecutive samples. Edges of SCL and SDA are detected on the filtered signals.
- Bus conditions:
  - START (and repeated START) = SDA falls while SCL high → go to ADDR from any state, bit counter = 0.
  - STOP = SDA rises while SCL high → go to IDLE from any state, release sda_oe, busy = 0.
- Shifting and line timing:
  - Bits are sampled on the filtered SCL rising edge, MSB first.
  - sda_oe changes only on the clk cycle after a filtered SCL falling edge, giving hold time.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WACK, RDATA, RACK, IGNORE.
  - ADDR: after 8 bits, if addr[7:1]==DEV_ADDR → ADDR_ACK and busy = 1; otherwise → IGNORE (no ACK, wait for START/STOP).
  - ADDR_ACK: drive sda_oe = 1 for the 9th clock, release on its falling edge. If R/W = 0 → PTR. If R/W = 1 → load mem[ptr] into the shifter and go to RDATA.
  - PTR: after 8 bits, ptr ← byte[DEPTH_LOG2-1:0] (upper bits ignored), then ACK in PTR_ACK → WDATA.
  - WDATA: after 8 bits, mem[ptr] ← byte; pulse wr_strobe with wr_addr = ptr and wr_data = byte; ptr increments; ACK in WACK → WDATA.
  - RDATA: sda_oe = ~shifter[7], updated after each SCL falling edge. After 8 bits, release SDA → RACK.
  - RACK: sample the host ACK on the 9th rising edge. SDA = 0 → ptr increments, load next byte, go to RDATA. SDA = 1 (NACK) → IGNORE with SDA released.
- Pointer: wraps modulo 2^DEPTH_LOG2 (e.g. 4'hF → 4'h0). The pointer persists across transactions, so a current-address read continues from the last position.
- Collision: if a cfg write and an I2C write happen in the same cycle to the same address, the I2C write wins and cfg_collision pulses. Different addresses → both writes complete.
- cfg_we is accepted in any state. Data read over I2C is latched into the shifter at byte load, so a cfg write during shifting takes effect on the next load.
- busy falls on STOP, on NACK, or on a START followed by an address mismatch.

Optional Feature:
- I2C_TGT_STRETCH_EN defined:
  - After each ACK/RACK 9th-clock falling edge, scl_oe = 1 for STRETCH_CYC clk cycles, then releases.
  - The FSM holds sda_oe stable while stretching.
  - STOP/START or reset clears scl_oe immediately.
- Undefined: scl_oe tied 0 and no stretch counter is built.

Test Plan:
- Write 0x50/W, ptr 0x03, data 0xA5, 0x5A, STOP → ACK on all 4 bytes; wr_strobe twice (addr 3/0xA5, addr 4/0x5A); mem[3]=0xA5, mem[4]=0x5A.
- Random read: 0x50/W, ptr 0x03, repeated START, 0x50/R, host ACK then NACK → host reads 0xA5, 0x5A; SDA released after NACK; busy = 0 after STOP.
- Address 0x51/W → no ACK (SDA high on 9th clock), no wr_strobe, busy stays 0, memory unchanged.
- Preload cfg mem[15]=0x11 and mem[0]=0x22; ptr 0x0F; read 2 bytes → 0x11 then 0x22 (pointer wrap).
- 1-cycle SDA glitch while SCL high with FILTER_LEN=3 → no START/STOP detected; assert fpga_resetn low mid-read → sda_oe = 0 the same cycle, memory = 0.
- With I2C_TGT_STRETCH_EN: after address ACK, scl_oe high for exactly 8 clk cycles; without the macro, scl_oe is constant 0.

Source files
------------

// File: rtl/i2c_id_rom_target.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_id_rom_target : I2C target emulating a 24C02-style ident EEPROM.     |
// | Optional clock stretching after each ACK: define I2C_TGT_STRETCH_EN.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module i2c_id_rom_target #(
   parameter logic [6:0] DEV_ADDR    = 7'h50,
   parameter int         DEPTH_LOG2  = 4,
   parameter int         FILTER_LEN  = 3,
   parameter int         STRETCH_CYC = 8
) (
   input  logic                  clk_50_max10,
   input  logic                  fpga_resetn,
   input  logic                  scl_in,
   input  logic                  sda_in,
   output logic                  sda_oe,
   output logic                  scl_oe,
   input  logic                  cfg_we,
   input  logic [DEPTH_LOG2-1:0] cfg_addr,
   input  logic [7:0]            cfg_wdata,
   output logic                  wr_strobe,
   output logic [DEPTH_LOG2-1:0] wr_addr,
   output logic [7:0]            wr_data,
   output logic                  cfg_collision,
   output logic                  busy
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int FCW   = $clog2(FILTER_LEN + 1);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      ADDR     = 4'd1,
      ADDR_ACK = 4'd2,
      PTR      = 4'd3,
      PTR_ACK  = 4'd4,
      WDATA    = 4'd5,
      WACK     = 4'd6,
      RDATA    = 4'd7,
      RACK     = 4'd8,
      IGNORE   = 4'd9
   } state_t;

   // Bit 1 carries SCL, bit 0 carries SDA through the whole input path.
   logic [1:0]          sync1_q, sync2_q, filt_q, fprev_q;
   logic [1:0][FCW-1:0] fcnt_q;

   always_ff @(posedge clk_50_max10 or negedge fpga_resetn) begin
      if (!fpga_resetn) begin
         sync1_q <= 2'b11;
         sync2_q <= 2'b11;
         filt_q  <= 2'b11;
         fprev_q <= 2'b11;
         fcnt_q  <= '0;
      end else begin
         sync1_q <= {scl_in, sda_in};
         sync2_q <= sync1_q;
         fprev_q <= filt_q;
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == filt_q[i]) begin
               fcnt_q[i] <= '0;
            end else if (fcnt_q[i] == FCW'(FILTER_LEN - 1)) begin
               filt_q[i] <= sync2_q[i];
               fcnt_q[i] <= '0;
            end else begin
               fcnt_q[i] <= fcnt_q[i] + FCW'(1);
            end
         end
      end
   end

   logic scl_rise, scl_fall, scl_high, bus_start, bus_stop, sda_f;
   assign sda_f     = filt_q[0];
   assign scl_rise  = filt_q[1] & ~fprev_q[1];
   assign scl_fall  = ~filt_q[1] & fprev_q[1];
   assign scl_high  = filt_q[1] & fprev_q[1];
   assign bus_start = scl_high & fprev_q[0] & ~filt_q[0];
   assign bus_stop  = scl_high & ~fprev_q[0] & filt_q[0];

   state_t                state_q, state_d;
   logic [3:0]            bcnt_q, bcnt_d;
   logic [7:0]            shreg_q, shreg_d;
   logic [DEPTH_LOG2-1:0] ptr_q, ptr_d, ptr_nxt;
   logic                  sda_oe_q, sda_oe_d;
   logic                  busy_q, busy_d;
   logic                  i2c_we;
   logic [7:0]            mem_q [DEPTH];
   logic                  wr_strobe_q, coll_q;
   logic [DEPTH_LOG2-1:0] wr_addr_q;
   logic [7:0]            wr_data_q;

   assign ptr_nxt = ptr_q + DEPTH_LOG2'(1);

   always_ff @(posedge clk_50_max10 or negedge fpga_resetn) begin
      if (!fpga_resetn) begin
         state_q  <= IDLE;
         bcnt_q   <= '0;
         shreg_q  <= '0;
         ptr_q    <= '0;
         sda_oe_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         bcnt_q   <= bcnt_d;
         shreg_q  <= shreg_d;
         ptr_q    <= ptr_d;
         sda_oe_q <= sda_oe_d;
         busy_q   <= busy_d;
      end
   end

   // Bits are shifted on SCL rise; completed bytes are acted on at the
   // following SCL fall so that SDA only ever moves while SCL is low.
   always_comb begin
      state_d  = state_q;
      bcnt_d   = bcnt_q;
      shreg_d  = shreg_q;
      ptr_d    = ptr_q;
      sda_oe_d = sda_oe_q;
      busy_d   = busy_q;
      i2c_we   = 1'b0;
      if (bus_stop) begin
         state_d  = IDLE;
         bcnt_d   = '0;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else if (bus_start) begin
         state_d  = ADDR;
         bcnt_d   = '0;
         sda_oe_d = 1'b0;
      end else if (scl_rise) begin
         case (state_q)
            ADDR, PTR, WDATA: begin
               shreg_d = {shreg_q[6:0], sda_f};
               bcnt_d  = bcnt_q + 4'd1;
            end
            RDATA:   bcnt_d  = bcnt_q + 4'd1;
            RACK:    shreg_d = {shreg_q[6:0], sda_f};
            default: ;
         endcase
      end else if (scl_fall) begin
         case (state_q)
            ADDR: if (bcnt_q == 4'd8) begin
               bcnt_d = '0;
               if (shreg_q[7:1] == DEV_ADDR) begin
                  state_d  = ADDR_ACK;
                  sda_oe_d = 1'b1;
                  busy_d   = 1'b1;
               end else begin
                  state_d = IGNORE;
                  busy_d  = 1'b0;
               end
            end
            ADDR_ACK: begin
               bcnt_d = '0;
               if (shreg_q[0]) begin
                  state_d  = RDATA;
                  shreg_d  = mem_q[ptr_q];
                  sda_oe_d = ~mem_q[ptr_q][7];
               end else begin
                  state_d  = PTR;
                  sda_oe_d = 1'b0;
               end
            end
            PTR: if (bcnt_q == 4'd8) begin
               state_d  = PTR_ACK;
               ptr_d    = shreg_q[DEPTH_LOG2-1:0];
               bcnt_d   = '0;
               sda_oe_d = 1'b1;
            end
            WDATA: if (bcnt_q == 4'd8) begin
               state_d  = WACK;
               i2c_we   = 1'b1;
               ptr_d    = ptr_nxt;
               bcnt_d   = '0;
               sda_oe_d = 1'b1;
            end
            PTR_ACK, WACK: begin
               state_d  = WDATA;
               sda_oe_d = 1'b0;
            end
            RDATA: begin
               if (bcnt_q == 4'd8) begin
                  state_d  = RACK;
                  bcnt_d   = '0;
                  sda_oe_d = 1'b0;
               end else begin
                  shreg_d  = {shreg_q[6:0], 1'b0};
                  sda_oe_d = ~shreg_q[6];
               end
            end
            RACK: begin
               if (!shreg_q[0]) begin
                  state_d  = RDATA;
                  ptr_d    = ptr_nxt;
                  shreg_d  = mem_q[ptr_nxt];
                  sda_oe_d = ~mem_q[ptr_nxt][7];
               end else begin
                  state_d  = IGNORE;
                  sda_oe_d = 1'b0;
                  busy_d   = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // A same-address cfg write loses to the bus write and is reported.
   always_ff @(posedge clk_50_max10 or negedge fpga_resetn) begin
      if (!fpga_resetn) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_strobe_q <= 1'b0;
         coll_q      <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         if (cfg_we && !(i2c_we && (cfg_addr == ptr_q))) mem_q[cfg_addr] <= cfg_wdata;
         if (i2c_we) begin
            mem_q[ptr_q] <= shreg_q;
            wr_addr_q    <= ptr_q;
            wr_data_q    <= shreg_q;
         end
         wr_strobe_q <= i2c_we;
         coll_q      <= cfg_we && i2c_we && (cfg_addr == ptr_q);
      end
   end

`ifdef I2C_TGT_STRETCH_EN
   localparam int SCW = $clog2(STRETCH_CYC + 1);
   logic [SCW-1:0] stretch_q;
   logic           ack_fall;
   assign ack_fall = scl_fall && ((state_q == ADDR_ACK) || (state_q == PTR_ACK) ||
                                  (state_q == WACK) || (state_q == RACK));

   always_ff @(posedge clk_50_max10 or negedge fpga_resetn) begin
      if (!fpga_resetn)               stretch_q <= '0;
      else if (bus_start || bus_stop) stretch_q <= '0;
      else if (ack_fall)              stretch_q <= SCW'(STRETCH_CYC);
      else if (stretch_q != '0)       stretch_q <= stretch_q - SCW'(1);
   end
   assign scl_oe = (stretch_q != '0);
`else
   // Constant low; the comparison only keeps the stretch length referenced.
   assign scl_oe = (STRETCH_CYC < 0);
`endif

   assign sda_oe        = sda_oe_q;
   assign busy          = busy_q;
   assign wr_strobe     = wr_strobe_q;
   assign wr_addr       = wr_addr_q;
   assign wr_data       = wr_data_q;
   assign cfg_collision = coll_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_id_rom_target.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_i2c_id_rom_target : directed bench driving an open-drain I2C host.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_i2c_id_rom_target;

   localparam int Q = 12;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       host_scl = 1'b1, host_sda = 1'b1;
   logic       sda_oe, scl_oe, wr_strobe, cfg_collision, busy;
   logic       cfg_we = 1'b0;
   logic [3:0] cfg_addr = '0, wr_addr;
   logic [7:0] cfg_wdata = '0, wr_data;
   logic       scl_line, sda_line;

   assign scl_line = host_scl & ~scl_oe;
   assign sda_line = host_sda & ~sda_oe;

   always #10 clk = ~clk;

   i2c_id_rom_target dut (
      .clk_50_max10 (clk),
      .fpga_resetn  (rst_n),
      .scl_in       (scl_line),
      .sda_in       (sda_line),
      .sda_oe       (sda_oe),
      .scl_oe       (scl_oe),
      .cfg_we       (cfg_we),
      .cfg_addr     (cfg_addr),
      .cfg_wdata    (cfg_wdata),
      .wr_strobe    (wr_strobe),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .cfg_collision(cfg_collision),
      .busy         (busy)
   );

   int         checks = 0, passes = 0;
   int         strobe_cnt = 0, coll_cnt = 0;
   logic [3:0] s_addr [16];
   logic [7:0] s_data [16];
   int         so_run = 0, so_first = 0;
   logic       so_seen = 1'b0;

   always @(posedge clk) begin
      if (wr_strobe) begin
         s_addr[strobe_cnt[3:0]] <= wr_addr;
         s_data[strobe_cnt[3:0]] <= wr_data;
         strobe_cnt <= strobe_cnt + 1;
      end
      if (cfg_collision) coll_cnt <= coll_cnt + 1;
      if (scl_oe) begin
         so_run  <= so_run + 1;
         so_seen <= 1'b1;
      end else begin
         if (so_run != 0 && so_first == 0) so_first <= so_run;
         so_run <= 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic scl_release();
      int n = 0;
      host_scl = 1'b1;
      while (scl_line !== 1'b1 && n < 1000) begin
         tick(1);
         n++;
      end
      if (n >= 1000) chk("scl_release_timeout", 32'd0, 32'd1);
   endtask

   // One SCL period; glitch flips SDA for a single clk cycle mid-high.
   task automatic bit_io(input logic b, input logic glitch, output logic s);
      host_sda = b;
      tick(Q);
      scl_release();
      tick(Q / 2);
      if (glitch) begin
         host_sda = ~b;
         tick(1);
         host_sda = b;
      end
      tick(Q / 2);
      s = sda_line;
      tick(Q);
      host_scl = 1'b0;
      tick(Q);
   endtask

   task automatic start_cond();
      if (host_scl == 1'b0) begin
         host_sda = 1'b1;
         tick(Q);
         scl_release();
         tick(Q);
      end
      host_sda = 1'b0;
      tick(Q);
      host_scl = 1'b0;
      tick(Q);
   endtask

   task automatic stop_cond();
      host_sda = 1'b0;
      tick(Q);
      scl_release();
      tick(Q);
      host_sda = 1'b1;
      tick(2 * Q);
   endtask

   task automatic write_byte(input logic [7:0] b, input logic [7:0] gmask, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_io(b[i], gmask[i], s);
      bit_io(1'b1, 1'b0, s);
      ack = ~s;
   endtask

   task automatic read_byte(input logic host_ack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_io(1'b1, 1'b0, s);
         d[i] = s;
      end
      bit_io(~host_ack, 1'b0, s);
   endtask

   task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
      cfg_addr  = a;
      cfg_wdata = d;
      cfg_we    = 1'b1;
      tick(1);
      cfg_we    = 1'b0;
   endtask

   // Sets the pointer, issues a repeated START and reads two bytes.
   task automatic read_two(input logic [7:0] ptr, input string tag,
                           input logic [7:0] e0, input logic [7:0] e1);
      logic       ack;
      logic [7:0] d;
      start_cond();
      write_byte(8'hA0, 8'h00, ack);
      chk({tag, "_addr_ack"}, 32'(ack), 32'd1);
      write_byte(ptr, 8'h00, ack);
      chk({tag, "_ptr_ack"}, 32'(ack), 32'd1);
      start_cond();
      write_byte(8'hA1, 8'h00, ack);
      chk({tag, "_raddr_ack"}, 32'(ack), 32'd1);
      read_byte(1'b1, d);
      chk({tag, "_byte0"}, 32'(d), 32'(e0));
      read_byte(1'b0, d);
      chk({tag, "_byte1"}, 32'(d), 32'(e1));
      tick(Q);
      chk({tag, "_sda_released"}, 32'(sda_oe), 32'd0);
      chk({tag, "_busy_nack"}, 32'(busy), 32'd0);
      stop_cond();
   endtask

   initial begin
      logic ack;
      int   n;

      tick(3);
      chk("rst_sda_oe", 32'(sda_oe), 32'd0);
      chk("rst_scl_oe", 32'(scl_oe), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_outputs", {22'd0, wr_strobe, cfg_collision, wr_addr, wr_data}, 32'd0);
      rst_n = 1'b1;
      tick(10);

      // Write A5, 5A at 3, 4.
      start_cond();
      write_byte(8'hA0, 8'h00, ack);
      chk("w_addr_ack", 32'(ack), 32'd1);
      chk("w_busy", 32'(busy), 32'd1);
      write_byte(8'h03, 8'h00, ack);
      chk("w_ptr_ack", 32'(ack), 32'd1);
      write_byte(8'hA5, 8'h00, ack);
      chk("w_d0_ack", 32'(ack), 32'd1);
      write_byte(8'h5A, 8'h00, ack);
      chk("w_d1_ack", 32'(ack), 32'd1);
      stop_cond();
      chk("w_busy_stop", 32'(busy), 32'd0);
      chk("w_strobes", 32'(strobe_cnt), 32'd2);
      chk("w_s0", {20'd0, s_addr[0], s_data[0]}, {20'd0, 4'h3, 8'hA5});
      chk("w_s1", {20'd0, s_addr[1], s_data[1]}, {20'd0, 4'h4, 8'h5A});

      read_two(8'h03, "rd", 8'hA5, 8'h5A);
      chk("rd_busy_stop", 32'(busy), 32'd0);

      // Foreign address: no ACK, nothing committed.
      start_cond();
      write_byte(8'hA2, 8'h00, ack);
      chk("x_addr_nack", 32'(ack), 32'd0);
      chk("x_busy", 32'(busy), 32'd0);
      write_byte(8'hFF, 8'h00, ack);
      chk("x_data_nack", 32'(ack), 32'd0);
      stop_cond();
      chk("x_strobes", 32'(strobe_cnt), 32'd2);

      // cfg_we held on the bus target address across the commit.
      start_cond();
      write_byte(8'hA0, 8'h00, ack);
      write_byte(8'h05, 8'h00, ack);
      cfg_addr  = 4'h5;
      cfg_wdata = 8'h77;
      cfg_we    = 1'b1;
      fork
         write_byte(8'hC3, 8'h00, ack);
         begin
            n = 0;
            while (wr_strobe !== 1'b1 && n < 2000) begin
               @(negedge clk);
               n++;
            end
            cfg_we = 1'b0;
         end
      join
      chk("c_ack", 32'(ack), 32'd1);
      stop_cond();
      chk("c_collisions", 32'(coll_cnt), 32'd1);
      chk("c_strobe", {20'd0, s_addr[2], s_data[2]}, {20'd0, 4'h5, 8'hC3});
      cfg_write(4'h6, 8'h66);
      read_two(8'h05, "c_rd", 8'hC3, 8'h66);

      // Pointer wrap from 15 to 0.
      cfg_write(4'hF, 8'h11);
      cfg_write(4'h0, 8'h22);
      read_two(8'h0F, "wrap", 8'h11, 8'h22);

      // Single-cycle SDA glitches while SCL high: fake STOP then fake START.
      start_cond();
      write_byte(8'hA0, 8'h00, ack);
      write_byte(8'h07, 8'h00, ack);
      write_byte(8'h3C, 8'b1010_0000, ack);
      chk("g_ack", 32'(ack), 32'd1);
      chk("g_busy", 32'(busy), 32'd1);
      stop_cond();
      chk("g_strobe", {20'd0, s_addr[3], s_data[3]}, {20'd0, 4'h7, 8'h3C});

      // Reset while the target drives bit 7 of 0x5A (low).
      start_cond();
      write_byte(8'hA0, 8'h00, ack);
      write_byte(8'h04, 8'h00, ack);
      start_cond();
      write_byte(8'hA1, 8'h00, ack);
      chk("r_sda_driving", 32'(sda_oe), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("r_sda_async", 32'(sda_oe), 32'd0);
      chk("r_busy_async", 32'(busy), 32'd0);
      host_scl = 1'b1;
      host_sda = 1'b1;
      tick(3);
      rst_n = 1'b1;
      tick(10);
      read_two(8'h03, "r_mem", 8'h00, 8'h00);

`ifdef I2C_TGT_STRETCH_EN
      chk("stretch_len", 32'(so_first), 32'd8);
`else
      chk("scl_oe_idle", 32'(so_seen), 32'd0);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
